// File: rtl/hlsm_job_sequencer_if.sv
// Job request, datapath start/done and result FIFO signals of hlsm_job_sequencer.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface hlsm_job_sequencer_if;
  logic        job_valid;
  logic        job_ready;
  logic        hlsm_start;
  logic        hlsm_done;
  logic [31:0] hlsm_avg;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        busy;
  logic [15:0] job_count;
  logic        err_timeout;

  modport slave (
    input  job_valid, hlsm_done, hlsm_avg, res_ready,
    output job_ready, hlsm_start, res_valid, res_data, busy, job_count, err_timeout
  );

  modport master (
    output job_valid, hlsm_done, hlsm_avg, res_ready,
    input  job_ready, hlsm_start, res_valid, res_data, busy, job_count, err_timeout
  );
endinterface

// File: rtl/hlsm_job_sequencer.sv
// Sequences one job at a time into the averaging datapath and queues each result in a FIFO.
// Start one cycle after accept; result visible one cycle after Done; jobs held off while FIFO full.
// Optional RUN watchdog with sticky error: define HLSM_SEQ_WATCHDOG_EN.
module hlsm_job_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input logic                 Clk,
  input logic                 Rst,
  hlsm_job_sequencer_if.slave bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT == 0) begin : g_param_check
    $error("hlsm_job_sequencer: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT nonzero");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   job_count_q, job_count_d;
  logic [31:0]   mem_q [FIFO_DEPTH];

`ifdef HLSM_SEQ_WATCHDOG_EN
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
`endif

  logic job_ready;
  logic res_valid;
  logic push;
  logic pop;
  logic start;

  // Outputs are gated by Rst so the block looks idle throughout the reset cycle itself.
  assign job_ready = !Rst && (state_q == IDLE) && (cnt_q < CW'(FIFO_DEPTH));
  assign res_valid = !Rst && (cnt_q != '0);
  assign pop       = res_valid && bus.res_ready;

  always_comb begin
    state_d     = state_q;
    job_count_d = job_count_q;
    push        = 1'b0;
    start       = 1'b0;
`ifdef HLSM_SEQ_WATCHDOG_EN
    wd_d        = wd_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.job_valid && job_ready) begin
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        start   = 1'b1;
        state_d = RUN;
`ifdef HLSM_SEQ_WATCHDOG_EN
        wd_d    = '0;
`endif
      end
      RUN: begin
        // Done takes priority over a timeout landing on the same cycle.
        if (bus.hlsm_done) begin
          push        = 1'b1;
          job_count_d = job_count_q + 16'd1;
          state_d     = IDLE;
        end
`ifdef HLSM_SEQ_WATCHDOG_EN
        else if (wd_q == WDW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      job_count_q <= '0;
`ifdef HLSM_SEQ_WATCHDOG_EN
      wd_q        <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      job_count_q <= job_count_d;
`ifdef HLSM_SEQ_WATCHDOG_EN
      wd_q        <= wd_d;
      err_q       <= err_d;
`endif
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.hlsm_avg;
    end
  end

  assign bus.job_ready  = job_ready;
  assign bus.hlsm_start = start && !Rst;
  assign bus.res_valid  = res_valid;
  assign bus.res_data   = mem_q[rd_ptr_q];
  assign bus.busy       = !Rst && (state_q != IDLE);
  assign bus.job_count  = job_count_q;
`ifdef HLSM_SEQ_WATCHDOG_EN
  assign bus.err_timeout = err_q;
`else
  assign bus.err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_hlsm_job_sequencer.sv
// Directed bench for hlsm_job_sequencer: datapath model plus result scoreboard queue.
// Watchdog steps follow HLSM_SEQ_WATCHDOG_EN.
module tb_hlsm_job_sequencer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 64;

  logic Clk = 1'b0;
  logic Rst;
  hlsm_job_sequencer_if bus ();

  hlsm_job_sequencer #(
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT   (TMO)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  int checks   = 0;
  int errors   = 0;
  int starts   = 0;
  int launches = 0;
  logic [31:0] exp_q [$];

  always @(posedge Clk) begin
    if (bus.hlsm_start === 1'b1) starts++;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a job, wait (bounded) for acceptance, then step into RUN.
  task automatic launch(input string tag);
    int n;
    n = 0;
    bus.job_valid = 1'b1;
    #1;
    while (bus.job_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_job_ready"}, bus.job_ready, 1);
    tick();
    bus.job_valid = 1'b0;
    launches++;
    check({tag, "_start_pulse"}, bus.hlsm_start, 1);
    check({tag, "_busy_launch"}, bus.busy, 1);
    tick();
    check({tag, "_start_low_run"}, bus.hlsm_start, 0);
  endtask

  // Called in the first RUN cycle; Done is raised lat cycles after the Start cycle.
  task automatic finish_job(input string tag, input logic [31:0] avg, input int lat, input bit pop_too);
    repeat (lat - 1) tick();
    check({tag, "_busy_run"}, bus.busy, 1);
    check({tag, "_job_ready_run"}, bus.job_ready, 0);
    check({tag, "_res_valid_pre"}, bus.res_valid, exp_q.size() != 0);
    bus.hlsm_done = 1'b1;
    bus.hlsm_avg  = avg;
    if (pop_too) begin
      bus.res_ready = 1'b1;
      check({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check({tag, "_pop_data"}, bus.res_data, exp_q.pop_front());
    end
    exp_q.push_back(avg);
    tick();
    bus.hlsm_done = 1'b0;
    bus.hlsm_avg  = 32'h0;
    bus.res_ready = 1'b0;
    #1;
    check({tag, "_res_valid_post"}, bus.res_valid, 1);
    check({tag, "_busy_after_done"}, bus.busy, 0);
  endtask

  task automatic run_job(input string tag, input logic [31:0] avg, input int lat);
    launch(tag);
    finish_job(tag, avg, lat, 1'b0);
  endtask

  task automatic pop_one(input string tag);
    check({tag, "_res_valid"}, bus.res_valid, 1);
    check({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
    if (exp_q.size() != 0) check({tag, "_res_data"}, bus.res_data, exp_q.pop_front());
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    #1;
  endtask

  initial begin
    Rst           = 1'b1;
    bus.job_valid = 1'b1;
    bus.hlsm_done = 1'b0;
    bus.hlsm_avg  = 32'h0;
    bus.res_ready = 1'b0;

    // Reset state, with a job already pending
    tick();
    tick();
    check("rst_job_ready", bus.job_ready, 0);
    check("rst_hlsm_start", bus.hlsm_start, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_busy", bus.busy, 0);
    Rst           = 1'b0;
    bus.job_valid = 1'b0;
    #1;
    check("idle_job_ready", bus.job_ready, 1);
    check("idle_job_count", bus.job_count, 0);
    check("idle_err_timeout", bus.err_timeout, 0);

    // Done while IDLE must be ignored
    bus.hlsm_done = 1'b1;
    bus.hlsm_avg  = 32'h0000_0BAD;
    tick();
    bus.hlsm_done = 1'b0;
    #1;
    check("idle_done_res_valid", bus.res_valid, 0);
    check("idle_done_job_count", bus.job_count, 0);

    // Single job, Done 13 cycles after Start
    run_job("single", 32'h0000_0010, 13);
    check("single_starts", starts, 1);
    check("single_job_count", bus.job_count, 1);
    pop_one("single_pop");
    check("single_empty", bus.res_valid, 0);

    // Back-to-back with consumer stalled: FIFO fills, fifth job held off
    run_job("b2b0", 32'h0000_00A0, 1);
    run_job("b2b1", 32'h0000_00A1, 2);
    run_job("b2b2", 32'h0000_00A2, 3);
    run_job("b2b3", 32'h0000_00A3, 1);
    bus.job_valid = 1'b1;
    repeat (5) tick();
    check("full_job_ready", bus.job_ready, 0);
    check("full_busy", bus.busy, 0);
    check("full_job_count", bus.job_count, 5);
    pop_one("full_pop0");
    check("after_pop_job_ready", bus.job_ready, 1);
    launch("b2b4");
    finish_job("b2b4", 32'h0000_00A4, 4, 1'b0);
    check("b2b_job_count", bus.job_count, 6);
    pop_one("b2b_pop1");
    pop_one("b2b_pop2");
    pop_one("b2b_pop3");
    pop_one("b2b_pop4");
    check("b2b_empty", bus.res_valid, 0);

    // Push and pop on the same edge with two entries queued
    run_job("pp0", 32'h0000_00C0, 2);
    run_job("pp1", 32'h0000_00C1, 2);
    launch("pp2");
    finish_job("pp2", 32'h0000_00C2, 3, 1'b1);
    pop_one("pp_pop1");
    pop_one("pp_pop2");
    check("pp_empty", bus.res_valid, 0);
    check("pp_job_count", bus.job_count, 9);

    // Reset five cycles after Start, then a late Done
    launch("rstrun");
    repeat (4) tick();
    Rst = 1'b1;
    #1;
    check("rstrun_busy", bus.busy, 0);
    check("rstrun_job_ready", bus.job_ready, 0);
    check("rstrun_start", bus.hlsm_start, 0);
    tick();
    Rst = 1'b0;
    bus.hlsm_done = 1'b1;
    bus.hlsm_avg  = 32'h0000_DEAD;
    tick();
    bus.hlsm_done = 1'b0;
    #1;
    check("late_done_res_valid", bus.res_valid, 0);
    check("late_done_job_count", bus.job_count, 0);
    check("late_done_busy", bus.busy, 0);
    exp_q.delete();

`ifdef HLSM_SEQ_WATCHDOG_EN
    // Datapath never answers: error after TMO cycles in RUN
    launch("wd");
    repeat (TMO - 1) tick();
    check("wd_busy_last", bus.busy, 1);
    check("wd_err_before", bus.err_timeout, 0);
    tick();
    check("wd_err_set", bus.err_timeout, 1);
    check("wd_idle", bus.busy, 0);
    check("wd_job_count", bus.job_count, 0);
    check("wd_no_push", bus.res_valid, 0);
    tick();
    check("wd_err_sticky", bus.err_timeout, 1);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    #1;
    check("wd_err_cleared", bus.err_timeout, 0);
    // Done on the exact timeout cycle wins
    launch("wdd");
    finish_job("wdd", 32'h0000_0064, TMO, 1'b0);
    check("wdd_err", bus.err_timeout, 0);
    check("wdd_job_count", bus.job_count, 1);
    pop_one("wdd_pop");
`else
    // No watchdog: RUN waits indefinitely
    launch("nowd");
    repeat (100) tick();
    check("nowd_busy", bus.busy, 1);
    check("nowd_err", bus.err_timeout, 0);
    finish_job("nowd", 32'h0000_0064, 1, 1'b0);
    check("nowd_job_count", bus.job_count, 1);
    pop_one("nowd_pop");
`endif

    // job_count wrap from a preloaded value
    force dut.job_count_q = 16'hFFFE;
    #1;
    release dut.job_count_q;
    #1;
    check("wrap_preload", bus.job_count, 16'hFFFE);
    run_job("wrap0", 32'h0000_0E00, 1);
    check("wrap_ffff", bus.job_count, 16'hFFFF);
    pop_one("wrap0_pop");
    run_job("wrap1", 32'h0000_0E01, 2);
    check("wrap_zero", bus.job_count, 16'h0000);
    pop_one("wrap1_pop");

    check("start_pulses_total", starts, launches);
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hlsm_job_sequencer.md
HLSM_JOB_SEQUENCER -- requirements
Module: hlsm_job_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, result FIFO entries; must be a power of two, >= 2.
REQ-002 SHALL have parameter TIMEOUT, default 64, watchdog limit in cycles spent in RUN.
REQ-003 SHALL have port Clk  input  1  single clock; all logic on posedge Clk.
REQ-004 SHALL have port Rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port job_valid  input  1  requester has a job pending.
REQ-006 SHALL have port job_ready  output  1  sequencer accepts the job this cycle.
REQ-007 SHALL have port hlsm_start  output  1  one-cycle Start pulse to the averaging datapath.
REQ-008 SHALL have port hlsm_done  input  1  Done from the datapath.
REQ-009 SHALL have port hlsm_avg  input  32  datapath result (avg).
REQ-010 SHALL have port res_valid  output  1  result FIFO not empty.
REQ-011 SHALL have port res_ready  input  1  consumer pops the FIFO head.
REQ-012 SHALL have port res_data  output  32  FIFO head, valid while res_valid.
REQ-013 SHALL have port busy  output  1  FSM not in IDLE.
REQ-014 SHALL have port job_count  output  16  completed jobs, wraps 0xFFFF->0x0000.
REQ-015 SHALL have port err_timeout  output  1  sticky watchdog error.

Function
REQ-016 FSM SHALL have states IDLE, LAUNCH, RUN.
REQ-017 job_ready SHALL be high, combinationally, only in IDLE with FIFO occupancy < FIFO_DEPTH; handshake = job_valid && job_ready.
REQ-018 On handshake, IDLE->LAUNCH; otherwise IDLE holds.
REQ-019 LAUNCH SHALL drive hlsm_start=1 for exactly that one cycle, clear the watchdog counter, then go to RUN; hlsm_start SHALL be 0 in every other state.
REQ-020 In RUN, hlsm_done=1 SHALL push hlsm_avg into the FIFO, increment job_count, and go to IDLE on the same edge.
REQ-021 hlsm_done SHALL be ignored in IDLE and LAUNCH (no push, no count).
REQ-022 res_valid SHALL rise the cycle after the push edge; res_data SHALL equal the pushed hlsm_avg.
REQ-023 A pop SHALL occur when res_valid && res_ready; res_ready with the FIFO empty SHALL have no effect.
REQ-024 Simultaneous push and pop SHALL leave occupancy unchanged and keep order; push into a full FIFO SHALL NOT occur, since a job is only accepted when space exists.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width log2(FIFO_DEPTH)+1.
REQ-026 At most one job SHALL be in flight; minimum handshake-to-next-job_ready spacing is 3 cycles (LAUNCH, RUN, IDLE).
REQ-027 busy SHALL equal (state != IDLE).

Reset
REQ-028 Rst=1 at a clock edge SHALL force state=IDLE, FIFO empty, job_count=0, err_timeout=0, watchdog=0.
REQ-029 While in reset: hlsm_start=0, res_valid=0, busy=0, job_ready=0.
REQ-030 Reset mid-RUN SHALL abandon the job; the datapath's late Done, arriving in IDLE, SHALL be ignored per REQ-021.

Configuration
REQ-031 With macro HLSM_SEQ_WATCHDOG_EN defined: in RUN the watchdog SHALL increment each cycle without hlsm_done; on the cycle it equals TIMEOUT-1 without hlsm_done, the FSM SHALL set err_timeout=1 (sticky until Rst), go to IDLE, push nothing, and leave job_count unchanged.
REQ-032 hlsm_done in the same cycle as the timeout SHALL win; the result is pushed and there is no error.
REQ-033 Without HLSM_SEQ_WATCHDOG_EN: no watchdog logic; RUN waits indefinitely; err_timeout tied 0.

Verification
REQ-034 Single job: datapath model returns Done 13 cycles after Start with avg=0x0000_0010 -> one hlsm_start pulse, res_valid the cycle after Done, res_data=0x10, job_count=1.
REQ-035 Back-to-back: 5 jobs, res_ready=0, FIFO_DEPTH=4 -> 4 results queued, job_ready stays 0 with job_valid=1; one pop -> 5th job accepted; FIFO order preserved.
REQ-036 Push/pop same cycle with occupancy 2 -> occupancy stays 2, res_data order correct.
REQ-037 Watchdog on, TIMEOUT=64, model never asserts Done -> err_timeout=1 after 64 cycles in RUN, state IDLE, job_count unchanged; Done at that exact cycle -> pushed, err_timeout=0.
REQ-038 Rst pulse 5 cycles after Start, then late Done -> no push, res_valid=0, job_count=0.
REQ-039 job_count wrap: preload via 65536 jobs (or forced) -> 0xFFFF then 0x0000.
